// File: rtl/cci_mpf_shim_rd_throttle.sv
// Read-request throttle shim. It sits between the AFU-side and FIU-side CCI
// channels, counts in-flight c0 read lines and raises c0TxAlmFull toward the
// AFU once the line budget is nearly spent. c0Tx is registered for one cycle.
// Every other channel passes straight through.
module cci_mpf_shim_rd_throttle #(
  parameter int MAX_OUTSTANDING_LINES = 256,
  parameter int ALM_FULL_SLACK        = 8,
  parameter int CNT_W                 = $clog2(MAX_OUTSTANDING_LINES + 1),
  parameter int HDR_W                 = 64,
  parameter int DATA_W                = 512,
  parameter int MMIO_W                = 64
) (
  input  logic                clk,
  input  logic                rst_n,

  // Reset from the FIU, forwarded to the AFU
  input  logic                i_fiu_reset,
  output logic                o_afu_reset,

  // c0Tx read requests: AFU -> shim -> FIU
  input  logic                i_afu_c0tx_valid,
  input  logic [1:0]          i_afu_c0tx_cl_len,
  input  logic [HDR_W-1:0]    i_afu_c0tx_hdr,
  output logic                o_fiu_c0tx_valid,
  output logic [1:0]          o_fiu_c0tx_cl_len,
  output logic [HDR_W-1:0]    o_fiu_c0tx_hdr,

  // c1Tx write requests, passed through
  input  logic                i_afu_c1tx_valid,
  input  logic [HDR_W-1:0]    i_afu_c1tx_hdr,
  input  logic [DATA_W-1:0]   i_afu_c1tx_data,
  output logic                o_fiu_c1tx_valid,
  output logic [HDR_W-1:0]    o_fiu_c1tx_hdr,
  output logic [DATA_W-1:0]   o_fiu_c1tx_data,

  // c2Tx MMIO read responses, passed through
  input  logic                i_afu_c2tx_valid,
  input  logic [HDR_W-1:0]    i_afu_c2tx_hdr,
  input  logic [MMIO_W-1:0]   i_afu_c2tx_data,
  output logic                o_fiu_c2tx_valid,
  output logic [HDR_W-1:0]    o_fiu_c2tx_hdr,
  output logic [MMIO_W-1:0]   o_fiu_c2tx_data,

  // Almost-full flags: FIU -> AFU
  input  logic                i_fiu_c0tx_alm_full,
  input  logic                i_fiu_c1tx_alm_full,
  output logic                o_afu_c0tx_alm_full,
  output logic                o_afu_c1tx_alm_full,

  // c0Rx responses and MMIO requests: FIU -> AFU
  input  logic                i_fiu_c0rx_rsp_valid,
  input  logic [3:0]          i_fiu_c0rx_resp_type,
  input  logic                i_fiu_c0rx_mmio_rd_valid,
  input  logic                i_fiu_c0rx_mmio_wr_valid,
  input  logic [HDR_W-1:0]    i_fiu_c0rx_hdr,
  input  logic [DATA_W-1:0]   i_fiu_c0rx_data,
  output logic                o_afu_c0rx_rsp_valid,
  output logic [3:0]          o_afu_c0rx_resp_type,
  output logic                o_afu_c0rx_mmio_rd_valid,
  output logic                o_afu_c0rx_mmio_wr_valid,
  output logic [HDR_W-1:0]    o_afu_c0rx_hdr,
  output logic [DATA_W-1:0]   o_afu_c0rx_data,

  // c1Rx write responses: FIU -> AFU
  input  logic                i_fiu_c1rx_rsp_valid,
  input  logic [HDR_W-1:0]    i_fiu_c1rx_hdr,
  output logic                o_afu_c1rx_rsp_valid,
  output logic [HDR_W-1:0]    o_afu_c1rx_hdr,

  // Software-visible status
  output logic [CNT_W-1:0]    o_outstanding_lines,
  output logic [CNT_W-1:0]    o_peak_lines,
  output logic                o_overflow_err
);

  // AlmFull rises early enough that ALM_FULL_SLACK further 4-line requests
  // still fit in the budget.
  localparam int THRESH = MAX_OUTSTANDING_LINES - 4 * ALM_FULL_SLACK;

  localparam logic [3:0]     RSP_RDLINE = 4'h0;
  localparam logic [CNT_W:0] MAX_EXT    = MAX_OUTSTANDING_LINES[CNT_W:0];
  localparam logic [CNT_W:0] THRESH_EXT = THRESH[CNT_W:0];

  if (THRESH <= 0) begin : g_bad_thresh
    $error("cci_mpf_shim_rd_throttle: ALM_FULL_SLACK too large for MAX_OUTSTANDING_LINES");
  end
  if (MAX_OUTSTANDING_LINES < 8 || MAX_OUTSTANDING_LINES > 4096) begin : g_bad_max
    $error("cci_mpf_shim_rd_throttle: MAX_OUTSTANDING_LINES outside 8..4096");
  end

  logic                r_c0tx_valid;
  logic [1:0]          r_c0tx_cl_len;
  logic [HDR_W-1:0]    r_c0tx_hdr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_peak;
  logic                r_err;
  logic                r_thr;

  logic [2:0]          w_len;
  logic [CNT_W:0]      w_inc;
  logic                w_dec;
  logic [CNT_W:0]      w_sum;
  logic [CNT_W:0]      w_diff;
  logic                w_under;
  logic                w_over;
  logic                w_illegal;
  logic [CNT_W:0]      w_next;

  // Straight passthrough channels
  assign o_afu_reset              = i_fiu_reset;
  assign o_fiu_c1tx_valid         = i_afu_c1tx_valid;
  assign o_fiu_c1tx_hdr           = i_afu_c1tx_hdr;
  assign o_fiu_c1tx_data          = i_afu_c1tx_data;
  assign o_fiu_c2tx_valid         = i_afu_c2tx_valid;
  assign o_fiu_c2tx_hdr           = i_afu_c2tx_hdr;
  assign o_fiu_c2tx_data          = i_afu_c2tx_data;
  assign o_afu_c1tx_alm_full      = i_fiu_c1tx_alm_full;
  assign o_afu_c0rx_rsp_valid     = i_fiu_c0rx_rsp_valid;
  assign o_afu_c0rx_resp_type     = i_fiu_c0rx_resp_type;
  assign o_afu_c0rx_mmio_rd_valid = i_fiu_c0rx_mmio_rd_valid;
  assign o_afu_c0rx_mmio_wr_valid = i_fiu_c0rx_mmio_wr_valid;
  assign o_afu_c0rx_hdr           = i_fiu_c0rx_hdr;
  assign o_afu_c0rx_data          = i_fiu_c0rx_data;
  assign o_afu_c1rx_rsp_valid     = i_fiu_c1rx_rsp_valid;
  assign o_afu_c1rx_hdr           = i_fiu_c1rx_hdr;

  // Registered c0Tx stage
  assign o_fiu_c0tx_valid  = r_c0tx_valid;
  assign o_fiu_c0tx_cl_len = r_c0tx_cl_len;
  assign o_fiu_c0tx_hdr    = r_c0tx_hdr;

  // Status outputs
  assign o_outstanding_lines = r_cnt;
  assign o_peak_lines        = r_peak;
  assign o_overflow_err      = r_err;

  // The FIU's own almost-full gets through with no added latency
  assign o_afu_c0tx_alm_full = i_fiu_c0tx_alm_full | r_thr;

  // Decode the request length; the illegal encoding 2 is charged as 4 lines
  always_comb begin
    w_len = 3'd4;
    case (i_afu_c0tx_cl_len)
      2'd0:    w_len = 3'd1;
      2'd1:    w_len = 3'd2;
      default: w_len = 3'd4;
    endcase
  end

  // Net the add and retire terms at CNT_W+1 bits, then clamp into 0..MAX
  always_comb begin
    w_inc     = i_afu_c0tx_valid ? {{(CNT_W-2){1'b0}}, w_len} : '0;
    w_dec     = i_fiu_c0rx_rsp_valid && (i_fiu_c0rx_resp_type == RSP_RDLINE);
    w_sum     = {1'b0, r_cnt} + w_inc;
    w_under   = w_dec && (w_sum == '0);
    w_diff    = w_sum - {{CNT_W{1'b0}}, w_dec};
    w_over    = !w_under && (w_diff > MAX_EXT);
    w_illegal = i_afu_c0tx_valid && (i_afu_c0tx_cl_len == 2'd2);
    w_next    = w_diff;
    if (w_under) begin
      w_next = '0;
    end else if (w_over) begin
      w_next = MAX_EXT;
    end
  end

  // c0Tx valid pipeline stage; the FIU reset squashes requests too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c0tx_valid <= 1'b0;
    end else begin
      r_c0tx_valid <= i_afu_c0tx_valid && !i_fiu_reset;
    end
  end

  // c0Tx header/length stage; these fields only matter alongside valid
  always_ff @(posedge clk) begin
    r_c0tx_cl_len <= i_afu_c0tx_cl_len;
    r_c0tx_hdr    <= i_afu_c0tx_hdr;
  end

  // Outstanding-line counter, peak tracker, sticky error and throttle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_peak <= '0;
      r_err  <= 1'b0;
      r_thr  <= 1'b0;
    end else if (i_fiu_reset) begin
      r_cnt  <= '0;
      r_thr  <= 1'b0;
    end else begin
      r_cnt  <= w_next[CNT_W-1:0];
      r_thr  <= (w_next >= THRESH_EXT);
      if (w_next > {1'b0, r_peak}) begin
        r_peak <= w_next[CNT_W-1:0];
      end
      if (w_under || w_over || w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_rd_throttle.sv
// Bench for cci_mpf_shim_rd_throttle. A driver applies directed, then random
// traffic and pushes the expected results into queues. A separate monitor
// pops those queues on the falling edge and compares them with the DUT.
module tb_cci_mpf_shim_rd_throttle;
  localparam int MAX    = 64;
  localparam int SLACK  = 8;
  localparam int THRESH = MAX - 4 * SLACK;
  localparam int CW     = $clog2(MAX + 1);
  localparam int HW     = 16;
  localparam int DW     = 32;
  localparam int MW     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_fiu_reset = 1'b0, o_afu_reset;
  logic i_afu_c0tx_valid = 1'b0;
  logic [1:0] i_afu_c0tx_cl_len = '0;
  logic [HW-1:0] i_afu_c0tx_hdr = '0;
  logic o_fiu_c0tx_valid;
  logic [1:0] o_fiu_c0tx_cl_len;
  logic [HW-1:0] o_fiu_c0tx_hdr;
  logic i_afu_c1tx_valid = 1'b0, o_fiu_c1tx_valid;
  logic [HW-1:0] i_afu_c1tx_hdr = '0, o_fiu_c1tx_hdr;
  logic [DW-1:0] i_afu_c1tx_data = '0, o_fiu_c1tx_data;
  logic i_afu_c2tx_valid = 1'b0, o_fiu_c2tx_valid;
  logic [HW-1:0] i_afu_c2tx_hdr = '0, o_fiu_c2tx_hdr;
  logic [MW-1:0] i_afu_c2tx_data = '0, o_fiu_c2tx_data;
  logic i_fiu_c0tx_alm_full = 1'b0, i_fiu_c1tx_alm_full = 1'b0;
  logic o_afu_c0tx_alm_full, o_afu_c1tx_alm_full;
  logic i_fiu_c0rx_rsp_valid = 1'b0, o_afu_c0rx_rsp_valid;
  logic [3:0] i_fiu_c0rx_resp_type = '0, o_afu_c0rx_resp_type;
  logic i_fiu_c0rx_mmio_rd_valid = 1'b0, o_afu_c0rx_mmio_rd_valid;
  logic i_fiu_c0rx_mmio_wr_valid = 1'b0, o_afu_c0rx_mmio_wr_valid;
  logic [HW-1:0] i_fiu_c0rx_hdr = '0, o_afu_c0rx_hdr;
  logic [DW-1:0] i_fiu_c0rx_data = '0, o_afu_c0rx_data;
  logic i_fiu_c1rx_rsp_valid = 1'b0, o_afu_c1rx_rsp_valid;
  logic [HW-1:0] i_fiu_c1rx_hdr = '0, o_afu_c1rx_hdr;
  logic [CW-1:0] o_outstanding_lines, o_peak_lines;
  logic o_overflow_err;

  cci_mpf_shim_rd_throttle #(
    .MAX_OUTSTANDING_LINES(MAX), .ALM_FULL_SLACK(SLACK),
    .HDR_W(HW), .DATA_W(DW), .MMIO_W(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_fiu_reset(i_fiu_reset), .o_afu_reset(o_afu_reset),
    .i_afu_c0tx_valid(i_afu_c0tx_valid), .i_afu_c0tx_cl_len(i_afu_c0tx_cl_len),
    .i_afu_c0tx_hdr(i_afu_c0tx_hdr),
    .o_fiu_c0tx_valid(o_fiu_c0tx_valid), .o_fiu_c0tx_cl_len(o_fiu_c0tx_cl_len),
    .o_fiu_c0tx_hdr(o_fiu_c0tx_hdr),
    .i_afu_c1tx_valid(i_afu_c1tx_valid), .i_afu_c1tx_hdr(i_afu_c1tx_hdr),
    .i_afu_c1tx_data(i_afu_c1tx_data),
    .o_fiu_c1tx_valid(o_fiu_c1tx_valid), .o_fiu_c1tx_hdr(o_fiu_c1tx_hdr),
    .o_fiu_c1tx_data(o_fiu_c1tx_data),
    .i_afu_c2tx_valid(i_afu_c2tx_valid), .i_afu_c2tx_hdr(i_afu_c2tx_hdr),
    .i_afu_c2tx_data(i_afu_c2tx_data),
    .o_fiu_c2tx_valid(o_fiu_c2tx_valid), .o_fiu_c2tx_hdr(o_fiu_c2tx_hdr),
    .o_fiu_c2tx_data(o_fiu_c2tx_data),
    .i_fiu_c0tx_alm_full(i_fiu_c0tx_alm_full), .i_fiu_c1tx_alm_full(i_fiu_c1tx_alm_full),
    .o_afu_c0tx_alm_full(o_afu_c0tx_alm_full), .o_afu_c1tx_alm_full(o_afu_c1tx_alm_full),
    .i_fiu_c0rx_rsp_valid(i_fiu_c0rx_rsp_valid), .i_fiu_c0rx_resp_type(i_fiu_c0rx_resp_type),
    .i_fiu_c0rx_mmio_rd_valid(i_fiu_c0rx_mmio_rd_valid),
    .i_fiu_c0rx_mmio_wr_valid(i_fiu_c0rx_mmio_wr_valid),
    .i_fiu_c0rx_hdr(i_fiu_c0rx_hdr), .i_fiu_c0rx_data(i_fiu_c0rx_data),
    .o_afu_c0rx_rsp_valid(o_afu_c0rx_rsp_valid), .o_afu_c0rx_resp_type(o_afu_c0rx_resp_type),
    .o_afu_c0rx_mmio_rd_valid(o_afu_c0rx_mmio_rd_valid),
    .o_afu_c0rx_mmio_wr_valid(o_afu_c0rx_mmio_wr_valid),
    .o_afu_c0rx_hdr(o_afu_c0rx_hdr), .o_afu_c0rx_data(o_afu_c0rx_data),
    .i_fiu_c1rx_rsp_valid(i_fiu_c1rx_rsp_valid), .i_fiu_c1rx_hdr(i_fiu_c1rx_hdr),
    .o_afu_c1rx_rsp_valid(o_afu_c1rx_rsp_valid), .o_afu_c1rx_hdr(o_afu_c1rx_hdr),
    .o_outstanding_lines(o_outstanding_lines), .o_peak_lines(o_peak_lines),
    .o_overflow_err(o_overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int stamp; int cnt; int peak; bit err; bit thr; } st_t;
  typedef struct { int stamp; logic [1:0] len; logic [HW-1:0] hdr; } tx_t;
  st_t stq[$];
  tx_t txq[$];

  // Reference model state: plain integers following the counting rules
  int  m_cnt  = 0;
  int  m_peak = 0;
  bit  m_err  = 1'b0;
  bit  m_thr  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge, then predict the
  // state that follows the next rising edge.
  task automatic step(input bit rst, input bit fres, input bit v, input logic [1:0] len,
                      input bit rsp, input logic [3:0] rtype, input bit mrd, input bit mwr,
                      input bit falm);
    int lines;
    int n;
    tx_t t;
    st_t s;
    @(posedge clk);
    #1;
    rst_n                    = !rst;
    i_fiu_reset              = fres;
    i_afu_c0tx_valid         = v;
    i_afu_c0tx_cl_len        = len;
    i_afu_c0tx_hdr           = HW'($urandom);
    i_fiu_c0rx_rsp_valid     = rsp;
    i_fiu_c0rx_resp_type     = rtype;
    i_fiu_c0rx_mmio_rd_valid = mrd;
    i_fiu_c0rx_mmio_wr_valid = mwr;
    i_fiu_c0rx_hdr           = HW'($urandom);
    i_fiu_c0rx_data          = DW'($urandom);
    i_fiu_c0tx_alm_full      = falm;
    i_fiu_c1tx_alm_full      = 1'($urandom);
    i_afu_c1tx_valid         = 1'($urandom);
    i_afu_c1tx_hdr           = HW'($urandom);
    i_afu_c1tx_data          = DW'($urandom);
    i_afu_c2tx_valid         = 1'($urandom);
    i_afu_c2tx_hdr           = HW'($urandom);
    i_afu_c2tx_data          = MW'($urandom);
    i_fiu_c1rx_rsp_valid     = 1'($urandom);
    i_fiu_c1rx_hdr           = HW'($urandom);

    if (rst) begin
      m_cnt = 0; m_peak = 0; m_err = 1'b0; m_thr = 1'b0;
    end else if (fres) begin
      m_cnt = 0; m_thr = 1'b0;
    end else begin
      lines = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      if (v && len == 2'd2) m_err = 1'b1;
      n = m_cnt + (v ? lines : 0) - ((rsp && rtype == 4'h0) ? 1 : 0);
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > MAX) begin n = MAX; m_err = 1'b1; end
      m_cnt = n;
      if (n > m_peak) m_peak = n;
      m_thr = (n >= THRESH);
      if (v) begin
        t.stamp = cyc + 1; t.len = len; t.hdr = i_afu_c0tx_hdr;
        txq.push_back(t);
      end
    end
    s.stamp = cyc + 1; s.cnt = m_cnt; s.peak = m_peak; s.err = m_err; s.thr = m_thr;
    stq.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0);
  endtask
  task automatic req(input logic [1:0] len);
    step(0, 0, 1, len, 0, 4'h0, 0, 0, 0);
  endtask
  task automatic rsps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 1, 4'h0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle against what the driver predicted
  always @(negedge clk) begin
    st_t e;
    tx_t t;
    bit have;
    bit exp_v;
    if (cyc >= 2) begin
      have = 1'b0;
      while (stq.size() > 0 && stq[0].stamp < cyc) void'(stq.pop_front());
      if (stq.size() > 0 && stq[0].stamp == cyc) begin
        e = stq.pop_front();
        have = 1'b1;
      end
      if (!rst_n) begin
        chk("rst_outstanding", 64'(o_outstanding_lines), 64'd0);
        chk("rst_peak", 64'(o_peak_lines), 64'd0);
        chk("rst_overflow", 64'(o_overflow_err), 64'd0);
        chk("rst_almfull", 64'(o_afu_c0tx_alm_full), 64'(i_fiu_c0tx_alm_full));
      end else if (have) begin
        chk("outstanding", 64'(o_outstanding_lines), 64'(e.cnt));
        chk("peak", 64'(o_peak_lines), 64'(e.peak));
        chk("overflow", 64'(o_overflow_err), 64'(e.err));
        chk("almfull", 64'(o_afu_c0tx_alm_full), 64'(e.thr | i_fiu_c0tx_alm_full));
      end

      while (txq.size() > 0 && txq[0].stamp < cyc) void'(txq.pop_front());
      exp_v = 1'b0;
      if (txq.size() > 0 && txq[0].stamp == cyc) begin
        t = txq.pop_front();
        exp_v = rst_n;
      end
      chk("c0tx_valid", 64'(o_fiu_c0tx_valid), 64'(exp_v));
      if (exp_v && o_fiu_c0tx_valid) begin
        chk("c0tx_len", 64'(o_fiu_c0tx_cl_len), 64'(t.len));
        chk("c0tx_hdr", 64'(o_fiu_c0tx_hdr), 64'(t.hdr));
      end

      chk("pass_c1tx", 64'({o_fiu_c1tx_valid, o_fiu_c1tx_hdr, o_fiu_c1tx_data}),
          64'({i_afu_c1tx_valid, i_afu_c1tx_hdr, i_afu_c1tx_data}));
      chk("pass_c2tx", 64'({o_afu_reset, o_afu_c1tx_alm_full, o_fiu_c2tx_valid,
                            o_fiu_c2tx_hdr, o_fiu_c2tx_data}),
          64'({i_fiu_reset, i_fiu_c1tx_alm_full, i_afu_c2tx_valid,
               i_afu_c2tx_hdr, i_afu_c2tx_data}));
      chk("pass_c0rx", 64'({o_afu_c0rx_rsp_valid, o_afu_c0rx_resp_type,
                            o_afu_c0rx_mmio_rd_valid, o_afu_c0rx_mmio_wr_valid,
                            o_afu_c0rx_data}),
          64'({i_fiu_c0rx_rsp_valid, i_fiu_c0rx_resp_type,
               i_fiu_c0rx_mmio_rd_valid, i_fiu_c0rx_mmio_wr_valid,
               i_fiu_c0rx_data}));
      chk("pass_rx_hdr", 64'({o_afu_c0rx_hdr, o_afu_c1rx_rsp_valid, o_afu_c1rx_hdr}),
          64'({i_fiu_c0rx_hdr, i_fiu_c1rx_rsp_valid, i_fiu_c1rx_hdr}));
    end
  end

  initial begin
    logic [1:0] len;
    // Reset held while the AFU tries to issue
    for (int i = 0; i < 5; i++) step(1, 0, 1, 2'd3, 0, 4'h0, 0, 0, i[0]);
    req(2'd0);
    idle(2);
    rsps(1);
    $display("reset and first request done, cycle %0d", cyc);

    // Ten 4-line requests, then drain one line per response
    for (int i = 0; i < 10; i++) req(2'd3);
    idle(1);
    rsps(40);
    idle(1);
    $display("mixed traffic done, cycle %0d", cyc);

    // Threshold crossing, filling to the exact budget, then draining below
    for (int i = 0; i < 16; i++) req(2'd3);
    idle(1);
    rsps(1);
    idle(1);
    rsps(32);
    idle(1);
    rsps(31);
    $display("threshold sweep done, cycle %0d", cyc);

    // Simultaneous request and response, plus non-retiring responses
    for (int i = 0; i < 5; i++) req(2'd0);
    step(0, 0, 1, 2'd1, 1, 4'h0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 0);
    step(0, 0, 0, 2'd0, 1, 4'h4, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 4'h0, 0, 1, 1);
    rsps(6);
    $display("simultaneous traffic done, cycle %0d", cyc);

    // Underflow is sticky through an FIU reset; the illegal length also flags
    rsps(1);
    step(0, 1, 0, 2'd0, 0, 4'h0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0);
    req(2'd2);
    idle(1);
    $display("error cases done, cycle %0d", cyc);

    // FIU reset mid-traffic clears the count but keeps the peak
    step(1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) req(2'd3);
    step(0, 1, 1, 2'd3, 0, 4'h0, 0, 0, 0);
    step(0, 1, 1, 2'd1, 1, 4'h0, 0, 0, 0);
    idle(2);
    $display("fiu reset pulse done, cycle %0d", cyc);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      len = 2'($urandom);
      if (len == 2'd2 && $urandom_range(0, 7) != 0) len = 2'd3;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 4, len,
           $urandom_range(0, 9) < 6, ($urandom_range(0, 9) == 0) ? 4'h4 : 4'h0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0);
    end
    idle(3);
    $display("random traffic done, cycle %0d", cyc);

    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL c0tx_queue_drain: %0d requests left, required 0", txq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
